ram_mar_seq: RTL

- Parametrised RAM-plus-MAR block for the 8-bit computer; drives and samples the shared tri-state bus under control of the MI, RI and RO microcode lines.
- Adds the following:
  - configurable data width and depth;
  - MAR auto-increment (MINC) for sequential loads and dumps;
  - a hardware clear sequencer that zero-fills memory after reset, so the RAM is now resettable from the computer reset button.
- Sits on the main bus beside the register file and ALU.

---
 rtl/ram_mar_seq_pkg.sv | 25 ++
 rtl/ram_mar_seq_mar_counter.sv | 35 +++
 rtl/ram_mar_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ram_mar_seq_pkg.sv
// ---------------------------------------------------------------------------
// ram_mar_seq_pkg
//   Shared definitions for the RAM + MAR bus block of the 8-bit computer.
//   - state_t   : sequencer states (2-bit encoding, CLEAR = 0, READY = 1)
//   - default width constants used when the block is instantiated bare
//   - is_last_addr(): terminal-count helper for the clear sweep
// ---------------------------------------------------------------------------
package ram_mar_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1
    } state_t;

    // True when every bit of the sweep counter is set, i.e. the last word.
    function automatic logic is_last_addr(input logic [31:0] cnt, input int addr_w);
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return ((cnt & mask) == mask);
    endfunction

endpackage

// File: rtl/ram_mar_seq_mar_counter.sv
// ---------------------------------------------------------------------------
// mar_counter
//   Memory address register: loadable, incrementing, asynchronous
//   active-low clear. Load has priority over increment; the increment
//   wraps naturally at 2**ADDR_W.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low clear (MAR -> 0)
//   load   - q <= din on posedge
//   inc    - q <= q + 1 on posedge when load is low
//   din    - load value
//   q      - registered address
// ---------------------------------------------------------------------------
module mar_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/ram_mar_seq.sv
// ---------------------------------------------------------------------------
// ram_mar_seq
//   RAM + MAR block on the shared computer bus. After reset an optional
//   sweep writes CLEAR_VAL to every word (busy high), then the block obeys
//   the MI / MINC / RI / RO microcode lines. Synchronous read, one cycle
//   latency; read-during-write returns the old word.
//
// Optional feature macro: RAM_MAR_PROG_EN
//   Adds the DIP-switch programming panel ports (prog_mode, prog_addr,
//   prog_data, prog_we). With prog_mode high in READY the panel address
//   drives both read and write, MI/MINC/RI are ignored and MAR holds.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   bus      - shared tri-state bus (DATA_W)
//   MI       - load MAR from bus low bits
//   MINC     - increment MAR (MI has priority)
//   RI       - write bus into mem[MAR]
//   RO       - drive read register onto bus (combinational enable)
//   busy     - high while the clear sweep runs
//   mar_out  - registered MAR value
// ---------------------------------------------------------------------------
module ram_mar_seq
    import ram_mar_seq_pkg::*;
#(
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL    = '0,
    parameter bit                CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              MI,
    input  logic              MINC,
    input  logic              RI,
    input  logic              RO,
    output logic              busy,
    output logic [ADDR_W-1:0] mar_out
`ifdef RAM_MAR_PROG_EN
    ,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_we
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   mar_q;
    logic                mar_load, mar_inc;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr, rd_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   rdata_reg;
    logic                drive_en;

    logic                prog_sel;
    logic [ADDR_W-1:0]   prog_addr_i;
    logic [DATA_W-1:0]   prog_data_i;
    logic                prog_we_i;

    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef RAM_MAR_PROG_EN
    assign prog_sel    = prog_mode;
    assign prog_addr_i = prog_addr;
    assign prog_data_i = prog_data;
    assign prog_we_i   = prog_we;
`else
    assign prog_sel    = 1'b0;
    assign prog_addr_i = '0;
    assign prog_data_i = '0;
    assign prog_we_i   = 1'b0;
`endif

    // ---------------- sequencer state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        mem_we     = 1'b0;
        mem_waddr  = mar_q;
        mem_wdata  = bus;
        mar_load   = 1'b0;
        mar_inc    = 1'b0;
        rd_addr    = mar_q;
        case (state_reg)
            ST_CLEAR: begin
                // MAR is never touched here, so it stays at its reset value.
                mem_we    = 1'b1;
                mem_waddr = cnt_reg;
                mem_wdata = CLEAR_VAL;
                cnt_next  = cnt_reg + 1'b1;
                if (is_last_addr(32'(cnt_reg), ADDR_W)) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (prog_sel) begin
                    rd_addr   = prog_addr_i;
                    mem_waddr = prog_addr_i;
                    mem_wdata = prog_data_i;
                    mem_we    = prog_we_i;
                end else begin
                    mar_load = MI;
                    mar_inc  = MINC & ~MI;
                    // With RO high the bus carries our own read data, so a
                    // simultaneous RI is a microcode slip and is dropped.
                    mem_we   = RI & ~RO;
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // ---------------- MAR ----------------
    mar_counter #(
        .ADDR_W (ADDR_W)
    ) u_mar (
        .clk   (clk),
        .rst_n (rst),
        .load  (mar_load),
        .inc   (mar_inc),
        .din   (bus[ADDR_W-1:0]),
        .q     (mar_q)
    );

    assign mar_out = mar_q;

    // ---------------- memory ----------------
    // No reset on the array: contents survive reset and only the sweep
    // (or normal writes) change them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= mem[rd_addr];
        end
    end

    // ---------------- bus drive ----------------
    // Gated by rst as well so the bus is released during reset even when
    // the sweep is disabled and the FSM resets straight into READY.
    assign drive_en = rst & RO & (state_reg == ST_READY);
    assign bus      = drive_en ? rdata_reg : {DATA_W{1'bz}};
    assign busy     = (state_reg == ST_CLEAR);

endmodule
